// File: rtl/pe_row_skewed_acc.sv
// Weight-stationary row of MAC PEs with internal input skew, double-buffered weights,
// in-flight tracking and a saturating accumulator across the vectors of a K tile.
module pe_row_skewed_acc #(
    parameter int MATRIX_SIZE    = 8,
    parameter int DATA_BW        = 8,
    parameter int WEIGHT_BW      = 8,
    parameter int PARTIAL_SUM_BW = 20,
    parameter int ACC_BW         = 32
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             wt_valid,
    output logic                             wt_ready,
    input  logic [MATRIX_SIZE*WEIGHT_BW-1:0] wt_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [MATRIX_SIZE*DATA_BW-1:0]   in_data,
    input  logic                             in_last,
    output logic [MATRIX_SIZE*DATA_BW-1:0]   df_out,
    output logic [MATRIX_SIZE-1:0]           df_valid,
    output logic                             out_valid,
    output logic [ACC_BW-1:0]                out_data,
    output logic                             out_sat
);
    localparam int PROD_BW = DATA_BW + WEIGHT_BW;
    localparam int CNT_BW  = $clog2(MATRIX_SIZE + 2) + 1;
    localparam logic signed [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

    typedef enum logic [1:0] {EMPTY, ACTIVE, DRAIN, SWAP} state_t;

    state_t                           state;
    logic                             in_ready_q, wt_ready_q;
    logic [MATRIX_SIZE*WEIGHT_BW-1:0] w_act, w_sh;
    logic [CNT_BW-1:0]                in_flight;
    logic                             accept, wt_accept;

    logic [DATA_BW-1:0]                      lane_in [MATRIX_SIZE];
    logic signed [PROD_BW-1:0]               prod [MATRIX_SIZE];
    logic [MATRIX_SIZE-1:0][DATA_BW-1:0]     d_q;
    logic signed [PARTIAL_SUM_BW-1:0]        ps_q [MATRIX_SIZE];
    logic [MATRIX_SIZE-1:0]                  v_q, l_q;

    logic                             final_valid, final_last;
    logic signed [PARTIAL_SUM_BW-1:0] psum_final;
    logic signed [ACC_BW:0]           acc_sum;
    logic signed [ACC_BW-1:0]         acc_q, acc_clamped;
    logic                             clamp_now, sat_q;
    logic                             out_valid_q, out_sat_q;
    logic [ACC_BW-1:0]                out_data_q;

    // A transfer happens on a rising edge where valid and ready are both high;
    // ready never depends on valid, and valid/data must hold until the transfer.
    assign accept    = in_valid & in_ready_q;
    assign wt_accept = wt_valid & wt_ready_q;
    assign in_ready  = in_ready_q;
    assign wt_ready  = wt_ready_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
            wt_ready_q <= 1'b1;
            w_act      <= '0;
            w_sh       <= '0;
        end else begin
            case (state)
                EMPTY, ACTIVE: begin
                    if (wt_accept) begin
                        w_sh       <= wt_data;
                        state      <= DRAIN;
                        in_ready_q <= 1'b0;
                        wt_ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (in_flight == '0) state <= SWAP;
                end
                SWAP: begin
                    w_act      <= w_sh;
                    w_sh       <= '0;
                    state      <= ACTIVE;
                    in_ready_q <= 1'b1;
                    wt_ready_q <= 1'b1;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            in_flight <= '0;
        end else begin
            case ({accept, final_valid})
                2'b10:   in_flight <= in_flight + CNT_BW'(1);
                2'b01:   in_flight <= in_flight - CNT_BW'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Lane i reaches PE i after i register stages so the psum chain meets it in step.
    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_skew
        logic [DATA_BW-1:0] lane_new;
        assign lane_new = accept ? in_data[i*DATA_BW +: DATA_BW] : '0;
        if (i == 0) begin : g_direct
            assign lane_in[i] = lane_new;
        end else begin : g_delay
            logic [DATA_BW-1:0] sr [i];
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    for (int j = 0; j < i; j++) sr[j] <= '0;
                end else begin
                    sr[0] <= lane_new;
                    for (int j = 1; j < i; j++) sr[j] <= sr[j-1];
                end
            end
            assign lane_in[i] = sr[i-1];
        end
    end

    always_comb begin
        for (int k = 0; k < MATRIX_SIZE; k++) begin
            prod[k] = PROD_BW'($signed(lane_in[k])) * PROD_BW'($signed(w_act[k*WEIGHT_BW +: WEIGHT_BW]));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            d_q <= '0;
            v_q <= '0;
            l_q <= '0;
            for (int k = 0; k < MATRIX_SIZE; k++) ps_q[k] <= '0;
        end else begin
            for (int k = 0; k < MATRIX_SIZE; k++) d_q[k] <= lane_in[k];
            v_q[0]  <= accept;
            l_q[0]  <= accept & in_last;
            ps_q[0] <= PARTIAL_SUM_BW'(prod[0]);
            for (int k = 1; k < MATRIX_SIZE; k++) begin
                v_q[k]  <= v_q[k-1];
                l_q[k]  <= l_q[k-1];
                ps_q[k] <= ps_q[k-1] + PARTIAL_SUM_BW'(prod[k]);
            end
        end
    end

    assign df_out      = d_q;
    assign df_valid    = v_q;
    assign final_valid = v_q[MATRIX_SIZE-1];
    assign final_last  = l_q[MATRIX_SIZE-1];
    assign psum_final  = ps_q[MATRIX_SIZE-1];

    // One guard bit: overflow shows as the top two bits of the sum disagreeing.
    always_comb begin
        acc_sum     = (ACC_BW+1)'(acc_q) + (ACC_BW+1)'(psum_final);
        clamp_now   = acc_sum[ACC_BW] != acc_sum[ACC_BW-1];
        acc_clamped = acc_sum[ACC_BW-1:0];
        if (clamp_now) acc_clamped = acc_sum[ACC_BW] ? ACC_MIN : ACC_MAX;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (final_valid) begin
                if (final_last) begin
                    out_data_q  <= acc_clamped;
                    out_sat_q   <= sat_q | clamp_now;
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                    sat_q       <= 1'b0;
                end else begin
                    acc_q <= acc_clamped;
                    sat_q <= sat_q | clamp_now;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_pe_row_skewed_acc.sv
// Directed bench for pe_row_skewed_acc: a 32-bit and a 20-bit accumulator instance share
// all inputs; each output pulse is checked against a queue of hand-computed results.
module tb_pe_row_skewed_acc;
    localparam int M = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wt_valid = 1'b0;
    logic [63:0] wt_data = '0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_last = 1'b0;

    logic        wt_ready, in_ready, out_valid, out_sat;
    logic [63:0] df_out;
    logic [7:0]  df_valid;
    logic [31:0] out_data;

    logic        wt_ready_s, in_ready_s, out_valid_s, out_sat_s;
    logic [63:0] df_out_s;
    logic [7:0]  df_valid_s;
    logic [19:0] out_data_s;

    int cyc = 0;
    int tests_run = 0;
    int failed = 0;

    // {sat, data} expected per output pulse; due cycle per pulse
    logic [32:0] exp_q[$];
    logic [32:0] exp_s_q[$];
    int          due_q[$];
    int          due_s_q[$];

    pe_row_skewed_acc dut (
        .clk(clk), .rstn(rstn), .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .df_out(df_out), .df_valid(df_valid), .out_valid(out_valid), .out_data(out_data),
        .out_sat(out_sat)
    );

    pe_row_skewed_acc #(.ACC_BW(20)) dut_s (
        .clk(clk), .rstn(rstn), .wt_valid(wt_valid), .wt_ready(wt_ready_s), .wt_data(wt_data),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
        .df_out(df_out_s), .df_valid(df_valid_s), .out_valid(out_valid_s), .out_data(out_data_s),
        .out_sat(out_sat_s)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [63:0] vec_all(input logic [7:0] v);
        logic [63:0] r;
        for (int i = 0; i < M; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [63:0] vec_ramp();
        logic [63:0] r;
        for (int i = 0; i < M; i++) r[i*8 +: 8] = 8'(i + 1);
        return r;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic load_wt(input logic [63:0] w);
        int n = 0;
        wt_data  = w;
        wt_valid = 1'b1;
        while (!wt_ready && n < 200) begin
            step(1);
            n++;
        end
        if (!wt_ready) begin
            tests_run++;
            failed++;
            $display("FAIL wt_handshake_timeout: wt_ready=0 after %0d cycles, required 1", n);
        end
        step(1);
        wt_valid = 1'b0;
    endtask

    // Leaves in_valid high so consecutive calls stream back to back.
    task automatic send_vec(input logic [63:0] d, input logic last);
        int n = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            step(1);
            n++;
        end
        if (!in_ready) begin
            tests_run++;
            failed++;
            $display("FAIL in_handshake_timeout: in_ready=0 after %0d cycles, required 1", n);
        end
        step(1);
    endtask

    task automatic push_exp(input logic [32:0] e, input logic [32:0] e_s);
        exp_q.push_back(e);
        exp_s_q.push_back(e_s);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rstn && in_valid && in_ready && in_last) begin
            due_q.push_back(cyc + 9);
            due_s_q.push_back(cyc + 9);
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                failed++;
                $display("FAIL main_unexpected: out_data=0x%0h, required no pulse", out_data);
            end else begin
                e = exp_q.pop_front();
                check("main_data", {32'd0, out_data}, {32'd0, e[31:0]});
                check("main_sat", {63'd0, out_sat}, {63'd0, e[32]});
                if (due_q.size() == 0) check("main_latency_missing", 64'd1, 64'd0);
                else check("main_latency", 64'(cyc), 64'(due_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (out_valid_s) begin
            if (exp_s_q.size() == 0) begin
                tests_run++;
                failed++;
                $display("FAIL sat_unexpected: out_data=0x%0h, required no pulse", out_data_s);
            end else begin
                e = exp_s_q.pop_front();
                check("sat_data", {32'd0, {{12{out_data_s[19]}}, out_data_s}}, {32'd0, e[31:0]});
                check("sat_flag", {63'd0, out_sat_s}, {63'd0, e[32]});
                if (due_s_q.size() == 0) check("sat_latency_missing", 64'd1, 64'd0);
                else check("sat_latency", 64'(cyc), 64'(due_s_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int lo;
        logic [63:0] exp_df;
        logic [7:0]  exp_dv;

        // Reset state
        rstn = 1'b0;
        step(3);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_wt_ready", {63'd0, wt_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_df_valid", {56'd0, df_valid}, 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        rstn = 1'b1;
        step(1);

        // Weights 1, ramp 1..8 -> 36
        load_wt(vec_all(8'd1));
        push_exp({1'b0, 32'd36}, {1'b0, 32'd36});
        send_vec(vec_ramp(), 1'b1);
        idle();
        step(12);

        // Weights 2, three all-3 vectors -> 3 * 48 = 144
        load_wt(vec_all(8'd2));
        push_exp({1'b0, 32'd144}, {1'b0, 32'd144});
        send_vec(vec_all(8'd3), 1'b0);
        send_vec(vec_all(8'd3), 1'b0);
        send_vec(vec_all(8'd3), 1'b1);
        idle();
        step(12);

        // Stream under A=1, swap to B=3 in the same cycle as the third vector
        load_wt(vec_all(8'd1));
        push_exp({1'b0, 32'd8},   {1'b0, 32'd8});
        push_exp({1'b0, 32'd16},  {1'b0, 32'd16});
        push_exp({1'b0, 32'd24},  {1'b0, 32'd24});
        push_exp({1'b0, 32'd96},  {1'b0, 32'd96});
        push_exp({1'b0, 32'd120}, {1'b0, 32'd120});
        send_vec(vec_all(8'd1), 1'b1);
        send_vec(vec_all(8'd2), 1'b1);
        in_data  = vec_all(8'd3);
        in_last  = 1'b1;
        in_valid = 1'b1;
        wt_data  = vec_all(8'd3);
        wt_valid = 1'b1;
        check("swap_in_ready", {63'd0, in_ready}, 64'd1);
        check("swap_wt_ready", {63'd0, wt_ready}, 64'd1);
        step(1);
        wt_valid = 1'b0;
        idle();
        lo = 0;
        while (!in_ready && lo < 100) begin
            lo++;
            step(1);
        end
        check("swap_stall_cycles", 64'(lo), 64'd10);
        send_vec(vec_all(8'd4), 1'b1);
        send_vec(vec_all(8'd5), 1'b1);
        idle();
        step(12);

        // df skew with B=3: ramp -> 108
        push_exp({1'b0, 32'd108}, {1'b0, 32'd108});
        send_vec(vec_ramp(), 1'b1);
        idle();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            exp_df = '0;
            exp_dv = '0;
            if (c <= M) begin
                exp_df[(c-1)*8 +: 8] = 8'(c);
                exp_dv[c-1] = 1'b1;
            end
            check("df_valid", {56'd0, df_valid}, {56'd0, exp_dv});
            check("df_out", df_out, exp_df);
        end
        step(12);

        // Reset mid-stream discards in-flight work
        send_vec(vec_all(8'd1), 1'b0);
        send_vec(vec_all(8'd1), 1'b1);
        idle();
        step(3);
        rstn = 1'b0;
        step(1);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        check("midrst_wt_ready", {63'd0, wt_ready}, 64'd1);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_df_valid", {56'd0, df_valid}, 64'd0);
        check("midrst_out_data", {32'd0, out_data}, 64'd0);
        check("midrst_out_sat", {63'd0, out_sat}, 64'd0);
        step(1);
        rstn = 1'b1;
        due_q.delete();
        due_s_q.delete();
        step(15);

        // Weights -128, five all -128 vectors: 5 * 131072; then a fresh tile
        load_wt(vec_all(8'h80));
        push_exp({1'b0, 32'd655360}, {1'b1, 32'd524287});
        push_exp({1'b0, 32'hFFFF_FC00}, {1'b0, 32'hFFFF_FC00});
        for (int k = 0; k < 5; k++) send_vec(vec_all(8'h80), (k == 4));
        send_vec(vec_all(8'd1), 1'b1);
        idle();

        // Drain the scoreboard
        lo = 0;
        while ((exp_q.size() != 0 || exp_s_q.size() != 0) && lo < 200) begin
            step(1);
            lo++;
        end
        check("drain_main_left", 64'(exp_q.size()), 64'd0);
        check("drain_sat_left", 64'(exp_s_q.size()), 64'd0);
        step(5);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
